// File: rtl/autb_delay_timer.sv
// autb_delay_timer: multi-channel (us, ns) delay timer for the analog TB harness.
// Each channel latches a request, counts microseconds, then nanoseconds, on clk,
// and pulses done on expiry. Remaining time is readable per channel.
//
// Optional feature: define AUTB_DELAY_TIMER_ABORT_EN to add the abort port,
// which cancels a busy channel without a done pulse.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   start    per-channel request strobe
//   us_req   per-channel us count, channel i at [i*CNT_W +: CNT_W]
//   ns_req   per-channel ns count, same packing
//   abort    per-channel cancel (only with AUTB_DELAY_TIMER_ABORT_EN)
//   busy     channel counting
//   done     one-cycle expiry pulse
//   us_left  remaining us per channel
//   ns_left  remaining ns within the current phase per channel
//   ignored  one-cycle pulse: start dropped because channel busy
module autb_delay_timer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CLK_PER_NS = 1,
  parameter int unsigned NS_PER_US  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*CNT_W-1:0] us_req,
  input  logic [NUM_CH*CNT_W-1:0] ns_req,
`ifdef AUTB_DELAY_TIMER_ABORT_EN
  input  logic [NUM_CH-1:0]       abort,
`endif
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] us_left,
  output logic [NUM_CH*CNT_W-1:0] ns_left,
  output logic [NUM_CH-1:0]       ignored
);

  localparam int unsigned PS_W  = (CLK_PER_NS > 1) ? $clog2(CLK_PER_NS) : 1;
  localparam int unsigned SUB_W = (NS_PER_US > 1) ? $clog2(NS_PER_US) : 1;
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_PER_NS - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(NS_PER_US - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_US   = 2'd1,
    ST_NS   = 2'd2
  } state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t             state_q, state_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [CNT_W-1:0]   us_q, us_d, ns_q, ns_d;
    logic               busy_q, done_q, ign_q;
    logic               done_d, ign_d;
    logic               tick;
    logic               start_c, abort_c;
    logic [CNT_W-1:0]   us_in, ns_in;

    assign start_c = start[g];
    assign us_in   = us_req[g*CNT_W +: CNT_W];
    assign ns_in   = ns_req[g*CNT_W +: CNT_W];
`ifdef AUTB_DELAY_TIMER_ABORT_EN
    assign abort_c = abort[g];
`else
    assign abort_c = 1'b0;
`endif

    // Next-state and counter update for one channel
    always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      sub_d   = sub_q;
      us_d    = us_q;
      ns_d    = ns_q;
      done_d  = 1'b0;
      ign_d   = 1'b0;
      tick    = (ps_q == PS_MAX);

      unique case (state_q)
        ST_IDLE: begin
          // abort beats a same-cycle start on an idle channel
          if (start_c && !abort_c) begin
            us_d  = us_in;
            ns_d  = ns_in;
            ps_d  = '0;
            sub_d = '0;
            if (us_in != '0)      state_d = ST_US;
            else if (ns_in != '0) state_d = ST_NS;
            else                  done_d  = 1'b1;
          end
        end
        ST_US: begin
          ign_d = start_c;
          ps_d  = tick ? '0 : ps_q + PS_W'(1);
          if (tick) begin
            if (sub_q == SUB_MAX) begin
              sub_d = '0;
              us_d  = us_q - CNT_W'(1);
              if (us_q == CNT_W'(1)) begin
                if (ns_q != '0) begin
                  state_d = ST_NS;
                end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
              end
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
        end
        ST_NS: begin
          ign_d = start_c;
          ps_d  = tick ? '0 : ps_q + PS_W'(1);
          if (tick) begin
            ns_d = ns_q - CNT_W'(1);
            if (ns_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Cancel a running channel silently
      if (abort_c && (state_q != ST_IDLE)) begin
        state_d = ST_IDLE;
        ps_d    = '0;
        sub_d   = '0;
        us_d    = '0;
        ns_d    = '0;
        done_d  = 1'b0;
        ign_d   = 1'b0;
      end
    end

    // Channel state and output registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        ps_q    <= '0;
        sub_q   <= '0;
        us_q    <= '0;
        ns_q    <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        ign_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ps_q    <= ps_d;
        sub_q   <= sub_d;
        us_q    <= us_d;
        ns_q    <= ns_d;
        busy_q  <= (state_d != ST_IDLE);
        done_q  <= done_d;
        ign_q   <= ign_d;
      end
    end

    assign busy[g]                    = busy_q;
    assign done[g]                    = done_q;
    assign ignored[g]                 = ign_q;
    assign us_left[g*CNT_W +: CNT_W]  = us_q;
    assign ns_left[g*CNT_W +: CNT_W]  = ns_q;
  end

endmodule

// File: tb/tb_autb_delay_timer.sv
// Testbench for autb_delay_timer: directed table, corner sequences, and
// randomized traffic against a cycle-count reference model.
module tb_autb_delay_timer;

  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int CPN = 2;
  localparam int NPU = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      start;
  logic [NCH*CW-1:0]   us_req, ns_req;
  logic [NCH-1:0]      abort_v;
  logic [NCH-1:0]      busy, done, ignored;
  logic [NCH*CW-1:0]   us_left, ns_left;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  autb_delay_timer #(
    .NUM_CH(NCH), .CNT_W(CW), .CLK_PER_NS(CPN), .NS_PER_US(NPU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .us_req(us_req),
    .ns_req(ns_req),
`ifdef AUTB_DELAY_TIMER_ABORT_EN
    .abort(abort_v),
`endif
    .busy(busy),
    .done(done),
    .us_left(us_left),
    .ns_left(ns_left),
    .ignored(ignored)
  );

  always #5 clk = ~clk;

  // Reference model: a channel is just "active for N cycles", with remaining
  // time derived from elapsed cycles by division.
  bit m_act [NCH];
  bit m_done[NCH];
  bit m_ign [NCH];
  int m_el  [NCH];
  int m_n   [NCH];
  int m_us  [NCH];
  int m_ns  [NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 1'b0;
      m_ign[c]  = 1'b0;
      if (rst) begin
        m_act[c] = 1'b0;
      end else if (m_act[c]) begin
        if (abort_v[c]) begin
          m_act[c] = 1'b0;
        end else begin
          if (start[c]) m_ign[c] = 1'b1;
          m_el[c]++;
          if (m_el[c] == m_n[c]) begin
            m_act[c]  = 1'b0;
            m_done[c] = 1'b1;
          end
        end
      end else if (start[c] && !abort_v[c]) begin
        m_us[c] = int'(us_req[c*CW +: CW]);
        m_ns[c] = int'(ns_req[c*CW +: CW]);
        m_n[c]  = (m_us[c] * NPU + m_ns[c]) * CPN;
        m_el[c] = 0;
        if (m_n[c] == 0) m_done[c] = 1'b1;
        else             m_act[c]  = 1'b1;
      end
    end
  end

  function automatic int exp_us(input int c);
    int usph;
    usph = m_us[c] * NPU * CPN;
    if (!m_act[c])        return 0;
    if (m_el[c] < usph)   return m_us[c] - m_el[c] / (NPU * CPN);
    return 0;
  endfunction

  function automatic int exp_ns(input int c);
    int usph;
    usph = m_us[c] * NPU * CPN;
    if (!m_act[c])        return 0;
    if (m_el[c] < usph)   return m_ns[c];
    return m_ns[c] - (m_el[c] - usph) / CPN;
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic d, input logic ig,
                                       input logic [CW-1:0] u, input logic [CW-1:0] n);
    return {29'd0, b, d, ig, u, n};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_model(input string tag, input int c);
    chk($sformatf("%s ch%0d", tag, c),
        pack(busy[c], done[c], ignored[c], us_left[c*CW +: CW], ns_left[c*CW +: CW]),
        pack(m_act[c], m_done[c], m_ign[c], CW'(exp_us(c)), CW'(exp_ns(c))));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input int u, input int n);
    start[ch]            = 1'b1;
    us_req[ch*CW +: CW]  = CW'(u);
    ns_req[ch*CW +: CW]  = CW'(n);
  endtask

  typedef struct {
    int ch;
    int us;
    int ns;
    int n_busy;
    int done_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{ch: 0, us: 1, ns: 3, n_busy: 14, done_cyc: 15};
    vecs[1] = '{ch: 1, us: 0, ns: 0, n_busy: 0,  done_cyc: 1};
    vecs[2] = '{ch: 0, us: 0, ns: 5, n_busy: 10, done_cyc: 11};
    vecs[3] = '{ch: 0, us: 2, ns: 0, n_busy: 16, done_cyc: 17};
    vecs[4] = '{ch: 1, us: 0, ns: 1, n_busy: 2,  done_cyc: 3};
    vecs[5] = '{ch: 1, us: 3, ns: 0, n_busy: 24, done_cyc: 25};

    rst     = 1'b1;
    start   = '0;
    us_req  = '0;
    ns_req  = '0;
    abort_v = '0;
    repeat (3) step();
    chk("reset busy",    64'(busy),    64'd0);
    chk("reset done",    64'(done),    64'd0);
    chk("reset ignored", 64'(ignored), 64'd0);
    chk("reset us_left", 64'(us_left), 64'd0);
    chk("reset ns_left", 64'(ns_left), 64'd0);
    rst = 1'b0;
    step();

    // Directed table: busy window and done cycle per request
    for (int r = 0; r < 6; r++) begin
      set_req(vecs[r].ch, vecs[r].us, vecs[r].ns);
      step();
      start = '0;
      for (int c = 1; c <= vecs[r].done_cyc + 1; c++) begin
        chk($sformatf("vec%0d busy c%0d", r, c), 64'(busy[vecs[r].ch]),
            64'(c <= vecs[r].n_busy));
        chk($sformatf("vec%0d done c%0d", r, c), 64'(done[vecs[r].ch]),
            64'(c == vecs[r].done_cyc));
        chk_model($sformatf("vec%0d c%0d", r, c), vecs[r].ch);
        if (r == 0 && c == 8) chk("us_left c8", 64'(us_left[0 +: CW]), 64'd1);
        if (r == 0 && c == 9) chk("us_left c9", 64'(us_left[0 +: CW]), 64'd0);
        step();
      end
      repeat (2) step();
    end

    // Start while busy is dropped and flagged
    set_req(0, 0, 5);
    step();
    start = '0;
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("ign ignored c%0d", c), 64'(ignored[0]), 64'(c == 5));
      chk($sformatf("ign done c%0d", c), 64'(done[0]), 64'(c == 11));
      if (c == 5) chk("ign ns_left c5", 64'(ns_left[0 +: CW]), 64'd3);
      start = '0;
      if (c == 4) set_req(0, 3, 1);
      step();
    end
    repeat (2) step();

    // Reset mid-count clears everything with no done
    set_req(0, 2, 0);
    step();
    start = '0;
    for (int c = 1; c < 6; c++) step();
    chk("rst busy before", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst all outputs", {busy, done, ignored, us_left[0 +: CW], ns_left[0 +: CW]}, 64'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (done[0]) seen++;
        step();
      end
      chk("rst no done", 64'(seen), 64'd0);
    end

    // Simultaneous starts and restart in the done cycle
    set_req(0, 0, 1);
    set_req(1, 0, 3);
    step();
    start = '0;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("sim done0 c%0d", c), 64'(done[0]), 64'(c == 3 || c == 8));
      chk($sformatf("sim done1 c%0d", c), 64'(done[1]), 64'(c == 7));
      chk($sformatf("sim busy0 c%0d", c), 64'(busy[0]), 64'(c <= 2 || (c >= 4 && c <= 7)));
      start = '0;
      if (c == 3) set_req(0, 0, 2);
      step();
    end
    start = '0;
    repeat (2) step();

`ifdef AUTB_DELAY_TIMER_ABORT_EN
    // Abort on a busy channel: silent return to idle
    set_req(0, 1, 0);
    step();
    start = '0;
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("abort busy c%0d", c), 64'(busy[0]), 64'(c <= 5));
      chk($sformatf("abort done c%0d", c), 64'(done[0]), 64'd0);
      if (c == 6) chk("abort us_left", 64'(us_left[0 +: CW]), 64'd0);
      abort_v = '0;
      if (c == 5) abort_v[0] = 1'b1;
      step();
    end
    // Abort and start together on an idle channel: start dropped, no ignored
    set_req(0, 0, 3);
    abort_v[0] = 1'b1;
    step();
    start   = '0;
    abort_v = '0;
    chk("abort+start busy", 64'(busy[0]), 64'd0);
    chk("abort+start ign",  64'(ignored[0]), 64'd0);
    chk("abort+start done", 64'(done[0]), 64'd0);
    repeat (2) step();
`endif

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) chk_model($sformatf("rand i%0d", i), c);
      rst     = ($urandom_range(0, 149) == 0);
      abort_v = '0;
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 5) == 0);
        us_req[c*CW +: CW] = CW'($urandom_range(0, 2));
        ns_req[c*CW +: CW] = CW'($urandom_range(0, 6));
`ifdef AUTB_DELAY_TIMER_ABORT_EN
        abort_v[c] = ($urandom_range(0, 39) == 0);
`endif
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
